// File: rtl/norm_sched_pkg.sv
// Shared types and constants for the norm_arbiter_sched clamp/normalize scheduler.
package norm_sched_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

  localparam int SAT_CNT_W     = 16;
  localparam int OUT_WIDTH_DEF = 8;

  function automatic int pix_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int PIX_MAX = pix_max(OUT_WIDTH_DEF);

endpackage

// File: rtl/norm_arbiter_sched_sat_clamp.sv
// Combinational signed -> unsigned pixel clamp with low/high saturation flags.
module sat_clamp
  import norm_sched_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [OUT_WIDTH-1:0] out_o,
  output logic                 lo_o,
  output logic                 hi_o
);

  localparam logic signed [IN_WIDTH-1:0] MAXV = IN_WIDTH'(pix_max(OUT_WIDTH));

  always_comb begin
    lo_o  = in_i[IN_WIDTH-1];
    hi_o  = !lo_o && ($signed(in_i) > MAXV);
    out_o = in_i[OUT_WIDTH-1:0];
    if (lo_o)      out_o = '0;
    else if (hi_o) out_o = '1;
  end

endmodule

// File: rtl/norm_arbiter_sched.sv
// Round-robin share of one clamp stage among NUM_REQ columns, with frame framing.
// Optional saturation counters: define NORM_SAT_COUNT_EN.
module norm_arbiter_sched
  import norm_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IN_WIDTH     = 24,
  parameter int OUT_WIDTH    = 8,
  parameter int FRAME_PIXELS = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          busy
`ifdef NORM_SAT_COUNT_EN
  ,
  input  logic                          sat_clr,
  output logic [SAT_CNT_W-1:0]          sat_lo_cnt,
  output logic [SAT_CNT_W-1:0]          sat_hi_cnt
`endif
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_PIXELS);

  out_state_e              state_q;
  logic [OUT_WIDTH-1:0]    data_q;
  logic [SRC_W-1:0]        src_q, rr_q, rr_d, win;
  logic [CNT_W-1:0]        pix_q, pix_d;
  logic                    last_q, last_d, fd_q;
  logic                    load, any_req, clamp_lo, clamp_hi;
  logic [IN_WIDTH-1:0]     win_data;
  logic [OUT_WIDTH-1:0]    clamped;

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_src    = src_q;
  assign out_last   = last_q;
  assign frame_done = fd_q;
  assign busy       = out_valid || (|req_valid);
  assign load       = !out_valid || out_ready;
  assign any_req    = |req_valid;

  // Scan downward from the farthest offset so the nearest requester at/after rr_q wins.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (req_valid[idx]) win = SRC_W'(idx);
    end
  end

  always_comb begin
    req_ready = '0;
    if (load && any_req) req_ready[win] = 1'b1;
  end

  assign win_data = req_data[win*IN_WIDTH +: IN_WIDTH];
  assign rr_d     = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign last_d   = (pix_q == CNT_W'(FRAME_PIXELS - 1));
  assign pix_d    = last_d ? '0 : pix_q + 1'b1;

  sat_clamp #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_clamp (
    .in_i (win_data),
    .out_o(clamped),
    .lo_o (clamp_lo),
    .hi_o (clamp_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
      rr_q    <= '0;
      pix_q   <= '0;
    end else begin
      fd_q <= (state_q == FULL) && out_ready && last_q;
      if (load) begin
        if (any_req) begin
          state_q <= FULL;
          data_q  <= clamped;
          src_q   <= win;
          last_q  <= last_d;
          pix_q   <= pix_d;
          rr_q    <= rr_d;
        end else begin
          state_q <= EMPTY;
        end
      end
    end
  end

`ifdef NORM_SAT_COUNT_EN
  logic [SAT_CNT_W-1:0] lo_cnt_q, hi_cnt_q;

  assign sat_lo_cnt = lo_cnt_q;
  assign sat_hi_cnt = hi_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else if (sat_clr) begin
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else if (load && any_req) begin
      if (clamp_lo && lo_cnt_q != '1) lo_cnt_q <= lo_cnt_q + 1'b1;
      if (clamp_hi && hi_cnt_q != '1) hi_cnt_q <= hi_cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_norm_arbiter_sched.sv
// Directed bench for norm_arbiter_sched (FRAME_PIXELS=4): clamp table, round-robin, stall, reset, framing.
module tb_norm_arbiter_sched;

  logic        clk, rst_n;
  logic [3:0]  req_valid;
  logic [95:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last, frame_done, busy;
`ifdef NORM_SAT_COUNT_EN
  logic        sat_clr;
  logic [15:0] sat_lo_cnt, sat_hi_cnt;
`endif

  int nchk = 0;
  int nfail = 0;

  norm_arbiter_sched #(.NUM_REQ(4), .IN_WIDTH(24), .OUT_WIDTH(8), .FRAME_PIXELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .frame_done(frame_done), .busy(busy)
`ifdef NORM_SAT_COUNT_EN
    , .sat_clr(sat_clr), .sat_lo_cnt(sat_lo_cnt), .sat_hi_cnt(sat_hi_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [23:0] data;
    logic [3:0]  exp_rdy;
    logic [7:0]  exp_data;
    logic [1:0]  exp_src;
    logic        exp_last;
    logic        exp_fd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [3:0] v, input logic [23:0] d);
    req_valid = v;
    req_data  = {4{d}};
  endtask

  initial begin
    // column/data -> hand-computed clamp result, winner and framing
    tbl[0] = '{4'b0001, 24'd300,     4'b0001, 8'd255, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b0001, 24'hFFFFFB,  4'b0001, 8'd0,   2'd0, 1'b0, 1'b0};
    tbl[2] = '{4'b0001, 24'd128,     4'b0001, 8'd128, 2'd0, 1'b0, 1'b0};
    tbl[3] = '{4'b0100, 24'd255,     4'b0100, 8'd255, 2'd2, 1'b1, 1'b0};
    tbl[4] = '{4'b1000, 24'd256,     4'b1000, 8'd255, 2'd3, 1'b0, 1'b1};
    tbl[5] = '{4'b0010, 24'h800000,  4'b0010, 8'd0,   2'd1, 1'b0, 1'b0};
    tbl[6] = '{4'b0110, 24'd0,       4'b0100, 8'd0,   2'd2, 1'b0, 1'b0};
    tbl[7] = '{4'b1001, 24'h7FFFFF,  4'b1000, 8'd255, 2'd3, 1'b1, 1'b0};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive_all(4'b0, 24'd0);
`ifdef NORM_SAT_COUNT_EN
    sat_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive_all(tbl[i].vld, tbl[i].data);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_src", i), 32'(out_src), 32'(tbl[i].exp_src));
      chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].exp_fd));
    end

    // idle cycle drains the last pixel of frame 2
    drive_all(4'b0, 24'd0);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_fd", 32'(frame_done), 32'd1);
    tick();
    chk("idle_fd_clear", 32'(frame_done), 32'd0);

    // all columns requesting: strict rotation, one grant per cycle
    req_valid = 4'hF;
    req_data  = {24'd40, 24'd30, 24'd20, 24'd10};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr%0d_src", k), 32'(out_src), 32'(k % 4));
      chk($sformatf("rr%0d_data", k), 32'(out_data), 32'(10 * (k % 4 + 1)));
    end

    // stall with FULL output: hold pixel, grant nothing
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("stall%0d_busy", k), 32'(busy), 32'd1);
      tick();
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_src", k), 32'(out_src), 32'd0);
      chk($sformatf("stall%0d_data", k), 32'(out_data), 32'd10);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("release_src", 32'(out_src), 32'd1);
    chk("release_data", 32'(out_data), 32'd20);

    // async reset mid-frame while FULL
    #3;
    rst_n = 1'b0;
    drive_all(4'b0, 24'd0);
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_all(4'b0100, 24'd7);
      tick();
      chk($sformatf("post%0d_last", k), 32'(out_last), 32'(k == 3));
      chk($sformatf("post%0d_data", k), 32'(out_data), 32'd7);
    end
    drive_all(4'b0, 24'd0);
    tick();
    chk("post_fd", 32'(frame_done), 32'd1);

`ifdef NORM_SAT_COUNT_EN
    rst_n = 1'b0;
    #2;
    chk("sat_rst_lo", 32'(sat_lo_cnt), 32'd0);
    chk("sat_rst_hi", 32'(sat_hi_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    begin
      logic [23:0] sv[5];
      sv = '{24'd300, 24'hFFFFFF, 24'd1000, 24'hFFFFCE, 24'd500};
      for (int k = 0; k < 5; k++) begin
        drive_all(4'b0001, sv[k]);
        tick();
      end
    end
    chk("sat_hi", 32'(sat_hi_cnt), 32'd3);
    chk("sat_lo", 32'(sat_lo_cnt), 32'd2);
    drive_all(4'b0001, 24'd999);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    drive_all(4'b0, 24'd0);
    chk("satclr_hi", 32'(sat_hi_cnt), 32'd0);
    chk("satclr_lo", 32'(sat_lo_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/norm_arbiter_sched.md
# norm_arbiter_sched

Round-robin scheduler that shares one clamp/normalize stage among `NUM_REQ` systolic-array column outputs. It accepts signed accumulator results through per-column valid/ready handshakes, clamps each result to unsigned `OUT_WIDTH` pixels, and streams them out with source tag and frame framing. It sits between the PE array drain and the output pixel buffer.

## Interface
- `NUM_REQ`, 4, number of requesting columns (≥2)
- `IN_WIDTH`, 24, signed accumulator width
- `OUT_WIDTH`, 8, unsigned pixel width
- `FRAME_PIXELS`, 1024, output beats per frame (≥2)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-column result valid
- `req_data`  in  NUM_REQ*IN_WIDTH  packed signed results, column i at [i*IN_WIDTH +: IN_WIDTH]
- `req_ready`  out  NUM_REQ  one-hot grant/accept
- `out_valid`  out  1  pixel valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  OUT_WIDTH  clamped pixel
- `out_src`  out  $clog2(NUM_REQ)  winning column index
- `out_last`  out  1  last pixel of frame
- `frame_done`  out  1  one-cycle pulse after last pixel handshake
- `busy`  out  1  out_valid or any req_valid

## Operation
- Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
- Accept condition: `load = !out_valid || out_ready`.
- When load and any req_valid: winner = first requesting column at or after `rr_ptr`, scanning upward with wrap NUM_REQ-1→0. req_ready[winner]=1 that cycle, all others 0. Register clamp(req_data[winner]), winner index, out_last; set FULL; rr_ptr ← winner+1 mod NUM_REQ.
- When load and no req_valid: go EMPTY, req_ready all 0, rr_ptr unchanged.
- FULL and !out_ready: out_data/out_src/out_last held stable; req_ready all 0.
- Clamp: in < 0 → 0; in > 2^OUT_WIDTH−1 → 2^OUT_WIDTH−1; else in[OUT_WIDTH-1:0].
- Pixel counter `pix_cnt` counts loaded beats. out_last registered as (pix_cnt == FRAME_PIXELS−1). pix_cnt wraps to 0 on that load.
- frame_done pulses on the cycle after the out handshake of a beat with out_last=1.
- Reset values: out_valid 0, out_data 0, out_src 0, out_last 0, frame_done 0, rr_ptr 0, pix_cnt 0, saturation counters 0. Reset mid-frame discards held pixel and restarts frame count.

## Timing
- req_ready is combinational from req_valid, rr_ptr and out_valid/out_ready (Mealy). It never depends on req_data.
- Latency: accepted request at edge N appears on out_data after edge N, i.e. 1 cycle.
- Throughput: 1 pixel/cycle with out_ready held high. Back-to-back handshake (drain + load in the same cycle) is mandatory.
- Fairness: a continuously requesting column waits at most NUM_REQ−1 grants.
- Requesters must hold req_valid/req_data until req_ready. Withdrawing early is illegal and not checked.

## Configuration
- `NORM_SAT_COUNT_EN` defined: adds input `sat_clr` (1) and outputs `sat_lo_cnt`, `sat_hi_cnt` (16 each).
  - Counters increment on each loaded beat clamped low or high, and saturate at 16'hFFFF.
  - `sat_clr` zeroes both counters and wins over a simultaneous increment.
- Undefined: ports and counters are absent. Datapath behaviour is identical.

## Structure
- Package `norm_sched_pkg` holds:
  - `out_state_e` (EMPTY, FULL)
  - `PIX_MAX` constant derived from OUT_WIDTH
  - `SAT_CNT_W`=16
- Sub-module `sat_clamp` (combinational signed→unsigned clamp, parameterised IN_WIDTH/OUT_WIDTH), instantiated once on the winner's data.

## Test plan
- Single column 0 with data 300, out_ready=1 → next cycle out_data=255, out_src=0. Data −5 → 0. Data 128 → 128.
- All 4 columns valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0,… one beat per cycle, exactly one req_ready high per cycle.
- out_ready low 3 cycles while FULL → out_data/out_src stable, req_ready all 0. On release, next winner continues round-robin order.
- FRAME_PIXELS=4, 9 beats → out_last on beats 4 and 8, frame_done pulse one cycle after each of those handshakes.
- Assert rst_n mid-frame with FULL → out_valid=0 immediately. Next frame's out_last lands on the 4th beat after reset.
- `NORM_SAT_COUNT_EN`: 3 high and 2 low overflows → sat_hi_cnt=3, sat_lo_cnt=2. sat_clr together with an overflow beat → both 0.
